// File: rtl/uncached_access_sequencer_if.sv
// LSU-side request/response and single-beat bus signals of the uncached access sequencer.
// 'slave' is the sequencer's view; 'master' is the view of the LSU/bus environment around it.
interface uncached_access_sequencer_if #(
    parameter int PA_BITS = 56,
    parameter int XLEN    = 64
);
    logic               ReqValid;
    logic [PA_BITS-1:0] ReqPAdr;
    logic               ReqWrite;
    logic [1:0]         ReqSize;
    logic [XLEN-1:0]    ReqWData;
    logic               Idempotent;
    logic               AccessFault;
    logic               CommitM;
    logic               FlushM;
    logic               Stall;
    logic               RspValid;
    logic [XLEN-1:0]    RspRData;
    logic               RspErr;
    logic               BusReq;
    logic [PA_BITS-1:0] BusAdr;
    logic               BusWrite;
    logic [1:0]         BusSize;
    logic [XLEN-1:0]    BusWData;
    logic               BusReady;
    logic [XLEN-1:0]    BusRData;
    logic               BusError;

    modport slave (
        input  ReqValid, ReqPAdr, ReqWrite, ReqSize, ReqWData,
        input  Idempotent, AccessFault, CommitM, FlushM,
        input  BusReady, BusRData, BusError,
        output Stall, RspValid, RspRData, RspErr,
        output BusReq, BusAdr, BusWrite, BusSize, BusWData
    );

    modport master (
        output ReqValid, ReqPAdr, ReqWrite, ReqSize, ReqWData,
        output Idempotent, AccessFault, CommitM, FlushM,
        output BusReady, BusRData, BusError,
        input  Stall, RspValid, RspRData, RspErr,
        input  BusReq, BusAdr, BusWrite, BusSize, BusWData
    );
endinterface

// File: rtl/uncached_access_sequencer.sv
// Sequences one uncacheable LSU access onto a single-beat address/data bus, holding
// non-idempotent accesses until commit and stalling the LSU until the response returns.
module uncached_access_sequencer #(
    parameter int PA_BITS     = 56,
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    uncached_access_sequencer_if.slave   io
);
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_COMMIT = 3'd1;
    localparam logic [2:0] S_ADDR        = 3'd2;
    localparam logic [2:0] S_DATA        = 3'd3;
    localparam logic [2:0] S_DONE        = 3'd4;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

    logic [2:0]         state_q, state_d;
    logic [PA_BITS-1:0] adr_q, adr_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               discard_q, discard_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               accept;

    // Faulted or flushed requests are dropped here and never touch the bus.
    assign accept = (state_q == S_IDLE) & io.ReqValid & ~io.AccessFault & ~io.FlushM;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        write_d   = write_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        discard_d = discard_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    adr_d     = io.ReqPAdr;
                    write_d   = io.ReqWrite;
                    size_d    = io.ReqSize;
                    wdata_d   = io.ReqWData;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = io.Idempotent ? S_ADDR : S_WAIT_COMMIT;
                end
            end
            S_WAIT_COMMIT: begin
                if (io.FlushM)       state_d = S_IDLE;
                else if (io.CommitM) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (io.BusReady) begin
                    // Address accepted: the transaction must finish, but a killed
                    // instruction still gets no response.
                    state_d = S_DATA;
                    cnt_d   = 8'd0;
                    if (io.FlushM) discard_d = 1'b1;
                end else if (io.FlushM) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (io.FlushM) discard_d = 1'b1;
                if (io.BusReady) begin
                    rdata_d = write_q ? '0 : io.BusRData;
                    err_d   = io.BusError;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_LIMIT) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                discard_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            write_q   <= 1'b0;
            size_q    <= 2'd0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            write_q   <= write_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
        end
    end

    assign io.Stall    = accept | (state_q == S_WAIT_COMMIT) | (state_q == S_ADDR) | (state_q == S_DATA);
    assign io.BusReq   = (state_q == S_ADDR);
    assign io.BusAdr   = adr_q;
    assign io.BusWrite = write_q;
    assign io.BusSize  = size_q;
    assign io.BusWData = wdata_q;
    assign io.RspValid = (state_q == S_DONE) & ~discard_q;
    assign io.RspRData = (state_q == S_DONE) ? rdata_q : '0;
    assign io.RspErr   = (state_q == S_DONE) & err_q;
endmodule

// File: tb/tb_uncached_access_sequencer.sv
// Self-checking bench: per-cycle vector table, directed multi-cycle corner cases and
// randomized traffic against a flag-based transaction model.
module tb_uncached_access_sequencer;
    localparam int PA = 56;
    localparam int XL = 64;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uncached_access_sequencer_if #(.PA_BITS(PA), .XLEN(XL)) bus ();

    uncached_access_sequencer #(.PA_BITS(PA), .XLEN(XL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .io(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {63'd0, act}, {63'd0, exp});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.ReqValid = 0; bus.ReqPAdr = '0; bus.ReqWrite = 0; bus.ReqSize = 2'd3;
        bus.ReqWData = 64'h1234; bus.Idempotent = 0; bus.AccessFault = 0;
        bus.CommitM = 0; bus.FlushM = 0; bus.BusReady = 0;
        bus.BusRData = 64'hDEAD_BEEF; bus.BusError = 0;
    endtask

    task automatic req(input logic idem, input logic wr, input logic [PA-1:0] adr);
        bus.ReqValid = 1; bus.Idempotent = idem; bus.ReqWrite = wr; bus.ReqPAdr = adr;
    endtask

    typedef struct {
        string        nm;
        logic         rv, idem, wr, fault, commit, flush, ready;
        logic [PA-1:0] adr;
        logic         stall, breq, rspv, rspe;
        logic [63:0]  rdata;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input string nm, input logic rv, idem, wr, fault, commit, flush, ready,
                       input logic [PA-1:0] adr, input logic stall, breq, rspv, rspe,
                       input logic [63:0] rdata);
        vec_t v;
        v.nm = nm; v.rv = rv; v.idem = idem; v.wr = wr; v.fault = fault; v.commit = commit;
        v.flush = flush; v.ready = ready; v.adr = adr; v.stall = stall; v.breq = breq;
        v.rspv = rspv; v.rspe = rspe; v.rdata = rdata;
        tbl.push_back(v);
    endtask

    // Reference model state: what the sequencer is holding, described by flags.
    logic          m_busy, m_cmt, m_adone, m_resp, m_kill, m_err, m_wr;
    int            m_waits;
    logic [PA-1:0] m_adr;
    logic [1:0]    m_size;
    logic [63:0]   m_wdata, m_rdata;

    initial begin
        reset = 1;
        idle_in();
        nxt(); nxt();
        @(negedge clk);
        chk1("rst_stall", bus.Stall, 0);
        chk1("rst_busreq", bus.BusReq, 0);
        chk1("rst_rspvalid", bus.RspValid, 0);
        chk("rst_rdata", bus.RspRData, 64'd0);
        nxt();
        reset = 0;

        // name rv id wr flt cmt fl rdy adr | stall breq rspv rspe rdata
        add("t5_fault",  1,1,0,1,0,0,1, 56'h0,    0,0,0,0, 64'h0);
        add("t5_idle",   0,0,0,0,0,0,1, 56'h0,    0,0,0,0, 64'h0);
        add("t1_accept", 1,1,0,0,0,0,1, 56'h1000, 1,0,0,0, 64'h0);
        add("t1_addr",   0,0,0,0,0,0,1, 56'h1000, 1,1,0,0, 64'h0);
        add("t1_data",   0,0,0,0,0,0,1, 56'h1000, 1,0,0,0, 64'h0);
        add("t1_done",   0,0,0,0,0,0,1, 56'h1000, 0,0,1,0, 64'hDEAD_BEEF);
        add("t2_accept", 1,0,1,0,0,0,1, 56'h2040, 1,0,0,0, 64'h0);
        add("t2_wait1",  0,0,0,0,0,0,1, 56'h2040, 1,0,0,0, 64'h0);
        add("t2_wait2",  0,0,0,0,0,0,1, 56'h2040, 1,0,0,0, 64'h0);
        add("t2_wait3",  0,0,0,0,0,0,1, 56'h2040, 1,0,0,0, 64'h0);
        add("t2_commit", 0,0,0,0,1,0,0, 56'h2040, 1,0,0,0, 64'h0);
        add("t2_addr",   0,0,0,0,1,0,1, 56'h2040, 1,1,0,0, 64'h0);
        add("t2_data",   0,0,0,0,1,0,1, 56'h2040, 1,0,0,0, 64'h0);
        add("t2_done",   0,0,0,0,0,0,1, 56'h2040, 0,0,1,0, 64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            idle_in();
            bus.ReqValid = tbl[i].rv; bus.Idempotent = tbl[i].idem; bus.ReqWrite = tbl[i].wr;
            bus.AccessFault = tbl[i].fault; bus.CommitM = tbl[i].commit; bus.FlushM = tbl[i].flush;
            bus.BusReady = tbl[i].ready; bus.ReqPAdr = tbl[i].adr;
            @(negedge clk);
            chk1({tbl[i].nm, "_stall"}, bus.Stall, tbl[i].stall);
            chk1({tbl[i].nm, "_busreq"}, bus.BusReq, tbl[i].breq);
            chk1({tbl[i].nm, "_rspvalid"}, bus.RspValid, tbl[i].rspv);
            chk1({tbl[i].nm, "_rsperr"}, bus.RspErr, tbl[i].rspe);
            if (tbl[i].rspv) chk({tbl[i].nm, "_rdata"}, bus.RspRData, tbl[i].rdata);
            if (tbl[i].breq) chk({tbl[i].nm, "_busadr"}, {8'd0, bus.BusAdr}, {8'd0, tbl[i].adr});
            nxt();
        end

        // Flush while waiting for commit: never issued.
        idle_in(); req(0, 0, 56'h3000);
        @(negedge clk); chk1("t3_accept_stall", bus.Stall, 1);
        nxt(); idle_in();
        @(negedge clk); chk1("t3_wait_busreq", bus.BusReq, 0);
        nxt(); bus.FlushM = 1;
        @(negedge clk); chk1("t3_flush_busreq", bus.BusReq, 0);
        nxt(); idle_in();
        @(negedge clk); chk1("t3_idle_stall", bus.Stall, 0);
        chk1("t3_idle_busreq", bus.BusReq, 0);
        nxt(); bus.CommitM = 1;
        @(negedge clk); chk1("t3_late_busreq", bus.BusReq, 0);
        chk1("t3_late_rspvalid", bus.RspValid, 0);

        // Flush after address acceptance: bus completes, response suppressed.
        nxt(); idle_in(); req(1, 0, 56'h4000); bus.BusReady = 1;
        @(negedge clk); chk1("t4_accept_stall", bus.Stall, 1);
        nxt(); idle_in(); bus.BusReady = 1;
        @(negedge clk); chk1("t4_addr_busreq", bus.BusReq, 1);
        nxt(); bus.FlushM = 1; bus.BusReady = 0;
        @(negedge clk); chk1("t4_data_stall", bus.Stall, 1);
        nxt(); bus.FlushM = 0; bus.BusReady = 1;
        @(negedge clk); chk1("t4_data2_stall", bus.Stall, 1);
        nxt(); bus.BusReady = 0;
        @(negedge clk); chk1("t4_done_rspvalid", bus.RspValid, 0);
        chk1("t4_done_stall", bus.Stall, 0);
        nxt(); req(1, 0, 56'h4100);
        @(negedge clk); chk1("t4_next_stall", bus.Stall, 1);
        nxt(); idle_in(); bus.BusReady = 1;
        @(negedge clk); chk1("t4_next_busreq", bus.BusReq, 1);
        chk("t4_next_busadr", {8'd0, bus.BusAdr}, 64'h4100);
        nxt();
        nxt();
        @(negedge clk); chk1("t4_next_rspvalid", bus.RspValid, 1);
        chk("t4_next_rdata", bus.RspRData, 64'hDEAD_BEEF);

        // Timeout with BusReady held low in the data phase.
        nxt(); idle_in(); req(1, 0, 56'h6000); bus.BusReady = 1;
        nxt(); idle_in(); bus.BusReady = 1;
        @(negedge clk); chk1("t6_addr_busreq", bus.BusReq, 1);
        for (int i = 1; i <= TO; i++) begin
            nxt(); bus.BusReady = 0;
            @(negedge clk); chk1($sformatf("t6_data%0d_stall", i), bus.Stall, 1);
            chk1($sformatf("t6_data%0d_rspvalid", i), bus.RspValid, 0);
        end
        nxt();
        @(negedge clk); chk1("t6_to_rspvalid", bus.RspValid, 1);
        chk1("t6_to_rsperr", bus.RspErr, 1);
        chk("t6_to_rdata", bus.RspRData, 64'd0);
        chk1("t6_to_stall", bus.Stall, 0);

        // Reset in the data phase.
        nxt(); req(1, 1, 56'h6100); bus.BusReady = 1;
        nxt(); idle_in(); bus.BusReady = 1;
        nxt(); bus.BusReady = 0; reset = 1;
        @(negedge clk); chk1("t6_rst_data_stall", bus.Stall, 1);
        nxt(); reset = 0;
        @(negedge clk); chk1("t6_rst_stall", bus.Stall, 0);
        chk1("t6_rst_busreq", bus.BusReq, 0);
        chk1("t6_rst_rspvalid", bus.RspValid, 0);
        chk1("t6_rst_rsperr", bus.RspErr, 0);

        // Randomized traffic against the model.
        nxt(); idle_in(); reset = 1;
        nxt();
        reset = 0;
        m_busy = 0; m_cmt = 0; m_adone = 0; m_resp = 0; m_kill = 0; m_err = 0; m_wr = 0;
        m_waits = 0; m_adr = '0; m_size = 0; m_wdata = 0; m_rdata = 0;
        for (int c = 0; c < 4000; c++) begin
            int rthr;
            logic acc, e_stall, e_breq, e_rspv, in_data;
            rthr = 1 + (c / 500);
            bus.ReqValid    = ($urandom_range(0, 1) == 1);
            bus.ReqPAdr     = PA'({$urandom(), $urandom()});
            bus.ReqWrite    = ($urandom_range(0, 1) == 1);
            bus.ReqSize     = 2'($urandom_range(0, 3));
            bus.ReqWData    = {$urandom(), $urandom()};
            bus.Idempotent  = ($urandom_range(0, 1) == 1);
            bus.AccessFault = ($urandom_range(0, 7) == 0);
            bus.CommitM     = ($urandom_range(0, 2) == 0);
            bus.FlushM      = ($urandom_range(0, 9) == 0);
            bus.BusReady    = ($urandom_range(0, 9) < rthr);
            bus.BusRData    = {$urandom(), $urandom()};
            bus.BusError    = ($urandom_range(0, 7) == 0);
            reset           = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            acc     = bus.ReqValid & ~bus.AccessFault & ~bus.FlushM;
            in_data = m_busy & m_cmt & m_adone & ~m_resp;
            e_stall = (~m_busy & acc) | (m_busy & ~m_resp);
            e_breq  = m_busy & m_cmt & ~m_adone & ~m_resp;
            e_rspv  = m_resp & ~m_kill;
            chk1($sformatf("rnd%0d_stall", c), bus.Stall, e_stall);
            chk1($sformatf("rnd%0d_busreq", c), bus.BusReq, e_breq);
            chk1($sformatf("rnd%0d_rspvalid", c), bus.RspValid, e_rspv);
            if (e_breq) begin
                chk($sformatf("rnd%0d_busadr", c), {8'd0, bus.BusAdr}, {8'd0, m_adr});
                chk1($sformatf("rnd%0d_buswrite", c), bus.BusWrite, m_wr);
                chk($sformatf("rnd%0d_bussize", c), {62'd0, bus.BusSize}, {62'd0, m_size});
            end
            if (in_data) chk($sformatf("rnd%0d_buswdata", c), bus.BusWData, m_wdata);
            if (e_rspv) begin
                chk($sformatf("rnd%0d_rdata", c), bus.RspRData, m_rdata);
                chk1($sformatf("rnd%0d_rsperr", c), bus.RspErr, m_err);
            end
            // Advance the model with this cycle's inputs.
            if (reset || m_resp) begin
                m_busy = 0; m_cmt = 0; m_adone = 0; m_resp = 0; m_kill = 0;
            end else if (!m_busy) begin
                if (acc) begin
                    m_busy = 1; m_cmt = bus.Idempotent; m_adone = 0; m_kill = 0;
                    m_adr = bus.ReqPAdr; m_wr = bus.ReqWrite; m_size = bus.ReqSize;
                    m_wdata = bus.ReqWData;
                end
            end else if (!m_cmt) begin
                if (bus.FlushM) m_busy = 0;
                else if (bus.CommitM) m_cmt = 1;
            end else if (!m_adone) begin
                if (bus.BusReady) begin
                    m_adone = 1; m_waits = 0;
                    if (bus.FlushM) m_kill = 1;
                end else if (bus.FlushM) begin
                    m_busy = 0; m_cmt = 0;
                end
            end else begin
                if (bus.FlushM) m_kill = 1;
                if (bus.BusReady) begin
                    m_rdata = m_wr ? 64'd0 : bus.BusRData;
                    m_err = bus.BusError; m_resp = 1;
                end else begin
                    m_waits++;
                    if (m_waits == TO) begin
                        m_rdata = 64'd0; m_err = 1; m_resp = 1;
                    end
                end
            end
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
